univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, 8, register width in bits (legal range 2..32).
REQ-002 SHALL have parameter SYNC_STAGES, 2, synchroniser depth for STEP_N (legal range 2..4).
REQ-003 SHALL have parameter CNT_W, 8, step-counter width.
REQ-004 SHALL have port CLK1  input  1  single system clock; all state on its rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port STEP_N  input  1  asynchronous active-low push button; each press requests one step.
REQ-007 SHALL have port MODE  input  3  operation applied on a step.
REQ-008 SHALL have port SIN  input  1  serial data in.
REQ-009 SHALL have port PIN  input  WIDTH  parallel load data.
REQ-010 SHALL have port Q  output  WIDTH  register contents.
REQ-011 SHALL have port SOUT  output  1  bit most recently shifted or rotated out.
REQ-012 SHALL have port STEP_CNT  output  CNT_W  count of executed non-hold steps.
REQ-013 SHALL have port STEP_PULSE  output  1  one-cycle strobe marking a detected press.

Function
REQ-014 STEP_N SHALL pass through a SYNC_STAGES flop chain, then a previous-sample flop; STEP_PULSE = previous sample high AND last sync stage low.
REQ-015 STEP_PULSE SHALL be high for exactly one cycle per falling edge of STEP_N, however long STEP_N stays low.
REQ-016 Latency: STEP_N falls before rising edge k -> STEP_PULSE high in the cycle after edge k+SYNC_STAGES-1 -> Q/SOUT/STEP_CNT update at edge k+SYNC_STAGES.
REQ-017 On a STEP_PULSE edge, Q SHALL update per MODE: 000 hold; 001 shift left, SIN into bit 0; 010 shift right, SIN into bit WIDTH-1; 011 rotate left; 100 rotate right; 101 load PIN; 110 arithmetic shift right (MSB replicated); 111 clear to 0.
REQ-018 SOUT SHALL register Q[WIDTH-1] on modes 001/011, Q[0] on modes 010/100/110, and hold its value in all other modes.
REQ-019 STEP_CNT SHALL increment by 1 on every STEP_PULSE with MODE != 000, wrapping from 2^CNT_W-1 to 0; mode 000 leaves it unchanged.
REQ-020 MODE, SIN and PIN SHALL be sampled only at the update edge; changes at other times SHALL have no effect.
REQ-021 Without STEP_PULSE, Q, SOUT and STEP_CNT SHALL hold.

Reset
REQ-022 RST high SHALL immediately force Q=0, SOUT=0, STEP_CNT=0 and STEP_PULSE=0, independent of CLK1.
REQ-023 RST SHALL load every synchroniser and previous-sample flop with 0 (pressed), so a button held low across reset release produces no step, and an idle-high button produces no step.
REQ-024 A press whose edge is in flight when RST asserts SHALL be discarded.

Structure
REQ-025 Mode encodings SHALL be named constants in shared package shift_reg_pkg, used by RTL and bench.
REQ-026 Synchroniser plus falling-edge detector SHALL be sub-module btn_edge_sync (parameter SYNC_STAGES; ports CLK1, RST, BTN_N, PULSE), reusable for other button-driven blocks.

Verification (WIDTH=8, SYNC_STAGES=2, CNT_W=8 unless stated)
REQ-027 RST pulse with STEP_N=1 -> Q=8'h00, SOUT=0, STEP_CNT=0, and no STEP_PULSE for 20 cycles after release.
REQ-028 MODE=001, SIN=1, three presses -> Q=8'h07, STEP_CNT=3; then SIN=0, three presses -> Q=8'h38, STEP_CNT=6, SOUT=0.
REQ-029 MODE=101, PIN=8'hA5, one press -> Q=8'hA5; then MODE=100, one press -> Q=8'hD2, SOUT=1; then MODE=110 from Q=8'h80 (after a load), two presses -> Q=8'hE0.
REQ-030 STEP_N held low for 100 cycles -> exactly one STEP_PULSE and Q update on the third rising edge after the fall; MODE=000 press -> STEP_PULSE high, Q and STEP_CNT unchanged.
REQ-031 RST asserted mid-cycle with Q=8'h5A and STEP_N low -> Q=0 before the next CLK1 edge; RST released with STEP_N still low -> no step until STEP_N is released and pressed again.
REQ-032 CNT_W=2, four non-hold presses -> STEP_CNT sequence 1,2,3,0.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
// Mode encodings are used by both the RTL and the bench.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  function automatic logic mode_counts(mode_e m);
    return (m != MODE_HOLD);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Push-button synchroniser with falling-edge strobe.
// Flops reset to "pressed" so a held or idle button gives no pulse.
module btn_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK1,
  input  logic RST,
  input  logic BTN_N,
  output logic PULSE
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], BTN_N};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign PULSE = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/univ_shift_reg.sv
// Button-stepped universal shift register with step counter.
// One operation per detected press, selected by MODE.
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             CLK1,
  input  logic             RST,
  input  logic             STEP_N,
  input  logic [2:0]       MODE,
  input  logic             SIN,
  input  logic [WIDTH-1:0] PIN,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT,
  output logic [CNT_W-1:0] STEP_CNT,
  output logic             STEP_PULSE
);

  logic             pulse;
  mode_e            mode;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             sout_q;
  logic             sout_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  btn_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK1 (CLK1),
    .RST  (RST),
    .BTN_N(STEP_N),
    .PULSE(pulse)
  );

  assign mode = mode_e'(MODE);

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    if (pulse) begin
      unique case (mode)
        MODE_HOLD: q_d = q_q;
        MODE_SHL: begin
          q_d    = {q_q[WIDTH-2:0], SIN};
          sout_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d    = {SIN, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        MODE_ROL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d = q_q[WIDTH-1];
        end
        MODE_ROR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        MODE_LOAD: q_d = PIN;
        MODE_ASR: begin
          q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        MODE_CLR: q_d = '0;
      endcase
      if (mode_counts(mode))
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      q_q    <= '0;
      sout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Q          = q_q;
  assign SOUT       = sout_q;
  assign STEP_CNT   = cnt_q;
  assign STEP_PULSE = pulse;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (8-bit and 2-bit counter).
// Expected states are queued per press and popped on each step.
module tb_univ_shift_reg;
  import shift_reg_pkg::*;

  logic       clk;
  logic       rst;
  logic       step_n;
  logic [2:0] mode;
  logic       sin;
  logic [7:0] pin;
  logic [7:0] q;
  logic       sout;
  logic [7:0] cnt;
  logic       pulse;
  logic [7:0] q2;
  logic       sout2;
  logic [1:0] cnt2;
  logic       pulse2;

  univ_shift_reg #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .CLK1(clk), .RST(rst), .STEP_N(step_n), .MODE(mode),
    .SIN(sin), .PIN(pin), .Q(q), .SOUT(sout),
    .STEP_CNT(cnt), .STEP_PULSE(pulse)
  );

  univ_shift_reg #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(2)) dut2 (
    .CLK1(clk), .RST(rst), .STEP_N(step_n), .MODE(mode),
    .SIN(sin), .PIN(pin), .Q(q2), .SOUT(sout2),
    .STEP_CNT(cnt2), .STEP_PULSE(pulse2)
  );

  typedef struct {
    logic [7:0] q;
    logic       sout;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulse_cnt = 0;
  logic [7:0] m_q;
  logic       m_sout;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt2;
  logic       mon_p;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (pulse) pulse_cnt++;

  always @(posedge clk) begin
    mon_p = pulse;
    #1;
    if (mon_p) begin
      exp_t e;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_step q=%h", q);
      end else begin
        e = sb.pop_front();
        if ({q, sout, cnt, q2, cnt2} !== {e.q, e.sout, e.cnt, e.q, e.cnt2}) begin
          n_fail++;
          $display("FAIL step q=%h sout=%b cnt=%0d q2=%h cnt2=%0d exp q=%h sout=%b cnt=%0d cnt2=%0d",
                   q, sout, cnt, q2, cnt2, e.q, e.sout, e.cnt, e.cnt2);
        end
      end
    end
  end

  task automatic model_reset();
    m_q = 8'h00; m_sout = 1'b0; m_cnt = 8'd0; m_cnt2 = 2'd0;
    sb.delete();
  endtask

  task automatic push_exp(input mode_e md, input logic s, input logic [7:0] p);
    exp_t e;
    case (md)
      MODE_SHL:  begin m_sout = m_q[7]; m_q = {m_q[6:0], s}; end
      MODE_SHR:  begin m_sout = m_q[0]; m_q = {s, m_q[7:1]}; end
      MODE_ROL:  begin m_sout = m_q[7]; m_q = {m_q[6:0], m_q[7]}; end
      MODE_ROR:  begin m_sout = m_q[0]; m_q = {m_q[0], m_q[7:1]}; end
      MODE_LOAD: m_q = p;
      MODE_ASR:  begin m_sout = m_q[0]; m_q = $signed(m_q) >>> 1; end
      MODE_CLR:  m_q = 8'h00;
      default:   ;
    endcase
    if (md != MODE_HOLD) begin
      m_cnt++;
      m_cnt2++;
    end
    e.q = m_q; e.sout = m_sout; e.cnt = m_cnt; e.cnt2 = m_cnt2;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL step_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic press(input mode_e md, input logic s, input logic [7:0] p, input int hold);
    @(negedge clk);
    mode = md; sin = s; pin = p;
    push_exp(md, s, p);
    step_n = 1'b0;
    repeat (hold) @(negedge clk);
    step_n = 1'b1;
    wait_drain();
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int pc;
    step_n = 1'b1; mode = 3'b000; sin = 1'b0; pin = 8'h00;
    rst = 1'b1;
    model_reset();
    #12;
    n_tests++;
    if ({q, sout, cnt, pulse} !== {8'h00, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state q=%h sout=%b cnt=%0d pulse=%b required 00/0/0/0", q, sout, cnt, pulse);
    end
    @(negedge clk);
    rst = 1'b0;
    pc = pulse_cnt;
    repeat (20) @(negedge clk);
    n_tests++;
    if (pulse_cnt !== pc) begin
      n_fail++;
      $display("FAIL reset_no_pulse got=%0d required=0", pulse_cnt - pc);
    end
  endtask

  task automatic test_shift_left();
    repeat (3) press(MODE_SHL, 1'b1, 8'h00, 3);
    n_tests++;
    if ({q, cnt} !== {8'h07, 8'd3}) begin
      n_fail++;
      $display("FAIL shl_ones q=%h cnt=%0d required 07/3", q, cnt);
    end
    repeat (3) press(MODE_SHL, 1'b0, 8'h00, 3);
    n_tests++;
    if ({q, cnt, sout} !== {8'h38, 8'd6, 1'b0}) begin
      n_fail++;
      $display("FAIL shl_zeros q=%h cnt=%0d sout=%b required 38/6/0", q, cnt, sout);
    end
  endtask

  task automatic test_load_rotate_asr();
    press(MODE_LOAD, 1'b0, 8'hA5, 2);
    n_tests++;
    if (q !== 8'hA5) begin
      n_fail++;
      $display("FAIL load q=%h required=a5", q);
    end
    press(MODE_ROR, 1'b0, 8'h00, 2);
    n_tests++;
    if ({q, sout} !== {8'hD2, 1'b1}) begin
      n_fail++;
      $display("FAIL ror q=%h sout=%b required d2/1", q, sout);
    end
    press(MODE_LOAD, 1'b0, 8'h80, 2);
    press(MODE_ASR, 1'b1, 8'h00, 2);
    press(MODE_ASR, 1'b0, 8'h00, 2);
    n_tests++;
    if (q !== 8'hE0) begin
      n_fail++;
      $display("FAIL asr q=%h required=e0", q);
    end
    press(MODE_SHR, 1'b1, 8'h00, 2);
    press(MODE_ROL, 1'b0, 8'h00, 2);
    press(MODE_CLR, 1'b1, 8'hFF, 2);
    n_tests++;
    if (q !== 8'h00) begin
      n_fail++;
      $display("FAIL clr q=%h required=00", q);
    end
  endtask

  task automatic test_long_press();
    int pc;
    logic [7:0] q_old;
    press(MODE_LOAD, 1'b0, 8'h11, 2);
    @(negedge clk);
    mode = MODE_SHL; sin = 1'b1;
    q_old = q;
    push_exp(MODE_SHL, 1'b1, 8'h00);
    pc = pulse_cnt;
    step_n = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_edge1 pulse=%b required=0", pulse);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({pulse, q} !== {1'b1, q_old}) begin
      n_fail++;
      $display("FAIL lat_edge2 pulse=%b q=%h required 1/%h", pulse, q, q_old);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({pulse, q} !== {1'b0, 8'h23}) begin
      n_fail++;
      $display("FAIL lat_edge3 pulse=%b q=%h required 0/23", pulse, q);
    end
    repeat (97) @(negedge clk);
    step_n = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (pulse_cnt - pc !== 1) begin
      n_fail++;
      $display("FAIL long_press pulses=%0d required=1", pulse_cnt - pc);
    end
    pc = pulse_cnt;
    press(MODE_HOLD, 1'b1, 8'hFF, 3);
    n_tests++;
    if ({q, cnt, pulse_cnt - pc} !== {8'h23, m_cnt, 32'd1}) begin
      n_fail++;
      $display("FAIL hold q=%h cnt=%0d pulses=%0d required 23/%0d/1", q, cnt, pulse_cnt - pc, m_cnt);
    end
  endtask

  task automatic test_idle_inputs();
    logic [7:0] q0;
    logic [7:0] c0;
    logic       s0;
    q0 = q; c0 = cnt; s0 = sout;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mode = 3'($urandom_range(7, 1));
      sin = 1'($urandom);
      pin = 8'($urandom);
    end
    @(negedge clk);
    n_tests++;
    if ({q, cnt, sout} !== {q0, c0, s0}) begin
      n_fail++;
      $display("FAIL idle_hold q=%h cnt=%0d sout=%b required %h/%0d/%b", q, cnt, sout, q0, c0, s0);
    end
  endtask

  task automatic test_reset_inflight();
    int pc;
    press(MODE_LOAD, 1'b0, 8'h5A, 2);
    @(negedge clk);
    mode = MODE_SHL; sin = 1'b1;
    step_n = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if ({q, sout, cnt, pulse} !== {8'h00, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset q=%h sout=%b cnt=%0d pulse=%b required 00/0/0/0", q, sout, cnt, pulse);
    end
    @(negedge clk);
    rst = 1'b0;
    pc = pulse_cnt;
    repeat (10) @(negedge clk);
    n_tests++;
    if ({q, pulse_cnt - pc} !== {8'h00, 32'd0}) begin
      n_fail++;
      $display("FAIL held_release q=%h pulses=%0d required 00/0", q, pulse_cnt - pc);
    end
    step_n = 1'b1;
    repeat (4) @(negedge clk);
    press(MODE_SHL, 1'b1, 8'h00, 2);
    n_tests++;
    if ({q, cnt} !== {8'h01, 8'd1}) begin
      n_fail++;
      $display("FAIL repress q=%h cnt=%0d required 01/1", q, cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    logic [1:0] want [4];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0;
    do_reset();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      press(MODE_ROL, 1'b0, 8'h00, 2);
      n_tests++;
      if (cnt2 !== want[i]) begin
        n_fail++;
        $display("FAIL cnt_wrap[%0d] cnt2=%0d required=%0d", i, cnt2, want[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift_left();
    test_load_rotate_asr();
    test_long_press();
    test_idle_inputs();
    test_reset_inflight();
    test_cnt_wrap();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
